// File: rtl/reg_file_p.sv
// Two-read/one-write register file with registered reads, write-first bypass,
// optional hard-wired zero register and a per-register pending scoreboard.
module reg_file_p #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  d_out_a,
    output logic [WIDTH-1:0]  d_out_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [WIDTH-1:0] r_d_out_a;
    logic [WIDTH-1:0] r_d_out_b;
    logic             r_busy_a;
    logic             r_busy_b;

    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [DEPTH-1:0] w_pend_d;
    logic             w_wr_ok;
    logic             w_claim_ok;
    logic             w_zero_a;
    logic             w_zero_b;
    logic [WIDTH-1:0] w_rd_data_a;
    logic [WIDTH-1:0] w_rd_data_b;
    logic             w_rd_busy_a;
    logic             w_rd_busy_b;

    assign w_wr_ok    = wr && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_claim_ok = claim && !((ZERO_REG != 0) && (claim_addr == '0));
    assign w_zero_a   = (ZERO_REG != 0) && (rd_addr_a == '0);
    assign w_zero_b   = (ZERO_REG != 0) && (rd_addr_b == '0);

    // Claim is applied after the write so a fresh producer keeps the register pending.
    always_comb begin
        w_mem_d  = r_mem;
        w_pend_d = r_pend;
        if (w_wr_ok) begin
            w_mem_d[wr_addr]  = d_in;
            w_pend_d[wr_addr] = 1'b0;
        end
        if (w_claim_ok) begin
            w_pend_d[claim_addr] = 1'b1;
        end
    end

    // Reads sample next-state storage, which gives write-first bypass for free.
    assign w_rd_data_a = w_zero_a ? '0 : w_mem_d[rd_addr_a];
    assign w_rd_data_b = w_zero_b ? '0 : w_mem_d[rd_addr_b];
    assign w_rd_busy_a = w_zero_a ? 1'b0 : w_pend_d[rd_addr_a];
    assign w_rd_busy_b = w_zero_b ? 1'b0 : w_pend_d[rd_addr_b];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend    <= '0;
            r_d_out_a <= '0;
            r_d_out_b <= '0;
            r_busy_a  <= 1'b0;
            r_busy_b  <= 1'b0;
        end else begin
            r_mem  <= w_mem_d;
            r_pend <= w_pend_d;
            if (rd_en_a) begin
                r_d_out_a <= w_rd_data_a;
                r_busy_a  <= w_rd_busy_a;
            end
            if (rd_en_b) begin
                r_d_out_b <= w_rd_data_b;
                r_busy_b  <= w_rd_busy_b;
            end
        end
    end

    assign d_out_a = r_d_out_a;
    assign d_out_b = r_d_out_b;
    assign busy_a  = r_busy_a;
    assign busy_b  = r_busy_b;

endmodule

// File: tb/tb_reg_file_p.sv
// Random and directed check of two reg_file_p configurations (8x16 plain,
// 16x32 with zero register) against an array-based reference model.
module tb_reg_file_p;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [3:0]  wa;
    logic [31:0] din;
    logic        cl;
    logic [3:0]  ca;
    logic        ena;
    logic [3:0]  aa;
    logic        enb;
    logic [3:0]  ab;

    logic [15:0] d0a, d0b;
    logic        b0a, b0b;
    logic [31:0] d1a, d1b;
    logic        b1a, b1b;

    int n_checks;
    int n_errors;

    // Reference model: index 0 = 8x16 plain, index 1 = 16x32 with zero register.
    logic [31:0] m_mem  [2][16];
    logic        m_pend [2][16];
    logic [31:0] m_da   [2];
    logic [31:0] m_db   [2];
    logic        m_ba   [2];
    logic        m_bb   [2];

    reg_file_p #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .wr_addr    (wa[2:0]),
        .d_in       (din[15:0]),
        .claim      (cl),
        .claim_addr (ca[2:0]),
        .rd_en_a    (ena),
        .rd_addr_a  (aa[2:0]),
        .rd_en_b    (enb),
        .rd_addr_b  (ab[2:0]),
        .d_out_a    (d0a),
        .d_out_b    (d0b),
        .busy_a     (b0a),
        .busy_b     (b0b)
    );

    reg_file_p #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .wr_addr    (wa),
        .d_in       (din),
        .claim      (cl),
        .claim_addr (ca),
        .rd_en_a    (ena),
        .rd_addr_a  (aa),
        .rd_en_b    (enb),
        .rd_addr_b  (ab),
        .d_out_a    (d1a),
        .d_out_b    (d1b),
        .busy_a     (b1a),
        .busy_b     (b1b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fold(input int k, input logic [3:0] a);
        return (k == 0) ? int'(a[2:0]) : int'(a);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[k][i]  = '0;
                m_pend[k][i] = 1'b0;
            end
            m_da[k] = '0;
            m_db[k] = '0;
            m_ba[k] = 1'b0;
            m_bb[k] = 1'b0;
        end
    endtask

    // One clock edge of the architectural behaviour: update storage, then reads see new state.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic        zero;
            logic [31:0] data;
            int          w, c, ra, rb;
            zero = (k == 1);
            data = (k == 0) ? {16'h0, din[15:0]} : din;
            w    = fold(k, wa);
            c    = fold(k, ca);
            ra   = fold(k, aa);
            rb   = fold(k, ab);
            if (wr && !(zero && w == 0)) begin
                m_mem[k][w]  = data;
                m_pend[k][w] = 1'b0;
            end
            if (cl && !(zero && c == 0)) m_pend[k][c] = 1'b1;
            if (ena) begin
                m_da[k] = (zero && ra == 0) ? 32'h0 : m_mem[k][ra];
                m_ba[k] = (zero && ra == 0) ? 1'b0 : m_pend[k][ra];
            end
            if (enb) begin
                m_db[k] = (zero && rb == 0) ? 32'h0 : m_mem[k][rb];
                m_bb[k] = (zero && rb == 0) ? 1'b0 : m_pend[k][rb];
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".d0a"}, {16'h0, d0a}, m_da[0]);
        check_eq({tag, ".d0b"}, {16'h0, d0b}, m_db[0]);
        check_eq({tag, ".b0a"}, {31'h0, b0a}, {31'h0, m_ba[0]});
        check_eq({tag, ".b0b"}, {31'h0, b0b}, {31'h0, m_bb[0]});
        check_eq({tag, ".d1a"}, d1a, m_da[1]);
        check_eq({tag, ".d1b"}, d1b, m_db[1]);
        check_eq({tag, ".b1a"}, {31'h0, b1a}, {31'h0, m_ba[1]});
        check_eq({tag, ".b1b"}, {31'h0, b1b}, {31'h0, m_bb[1]});
    endtask

    // Drive inputs (called 1 time unit after an edge), clock once, compare.
    task automatic cyc(input string tag,
                       input logic wr_, input logic [3:0] wa_, input logic [31:0] din_,
                       input logic cl_, input logic [3:0] ca_,
                       input logic ena_, input logic [3:0] aa_,
                       input logic enb_, input logic [3:0] ab_);
        wr = wr_; wa = wa_; din = din_; cl = cl_; ca = ca_;
        ena = ena_; aa = aa_; enb = enb_; ab = ab_;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".imm"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        {wr, wa, din, cl, ca, ena, aa, enb, ab} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Make outputs nonzero, then reset mid-cycle with a read of r5 in flight.
        cyc("pre", 1, 4'd5, 32'hA5A5_5A5A, 1, 4'd5, 1, 4'd5, 1, 4'd5);
        ena = 1'b1; aa = 4'd5; wr = 1'b1; wa = 4'd5; din = 32'h1111_2222;
        async_reset("rst");
        for (int i = 0; i < 16; i++) begin
            cyc("rdall", 0, 0, 0, 0, 0, 1, 4'(i), 1, 4'(15 - i));
        end

        cyc("wr3", 1, 4'd3, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0);
        cyc("rd3", 0, 0, 0, 0, 0, 1, 4'd3, 1, 4'd4);
        check_eq("beef", {16'h0, d0a}, 32'h0000_BEEF);
        check_eq("r4zero", {16'h0, d0b}, 32'h0);

        cyc("byp", 1, 4'd6, 32'h0000_1234, 0, 0, 1, 4'd6, 1, 4'd6);
        check_eq("byp_a", {16'h0, d0a}, 32'h0000_1234);
        check_eq("byp_b", {16'h0, d0b}, 32'h0000_1234);

        cyc("clm2", 0, 0, 0, 1, 4'd2, 0, 0, 0, 0);
        cyc("rdclm2", 0, 0, 0, 0, 0, 1, 4'd2, 0, 0);
        check_eq("busy2", {31'h0, b0a}, 32'h1);
        cyc("wr2", 1, 4'd2, 32'h0000_00AA, 0, 0, 1, 4'd2, 0, 0);
        check_eq("wr2busy", {31'h0, b0a}, 32'h0);
        cyc("clmwr2", 1, 4'd2, 32'h0000_00BB, 1, 4'd2, 1, 4'd2, 0, 0);
        check_eq("clmwr2d", {16'h0, d0a}, 32'h0000_00BB);
        check_eq("clmwr2b", {31'h0, b0a}, 32'h1);

        cyc("wr1", 1, 4'd1, 32'h0000_5555, 0, 0, 0, 0, 0, 0);
        cyc("rd1", 0, 0, 0, 0, 0, 1, 4'd1, 0, 0);
        cyc("hold", 1, 4'd1, 32'h0000_7777, 0, 0, 0, 4'd1, 0, 0);
        cyc("hold2", 0, 0, 0, 0, 0, 0, 4'd1, 0, 0);
        check_eq("hold_a", {16'h0, d0a}, 32'h0000_5555);
        cyc("unhold", 0, 0, 0, 0, 0, 1, 4'd1, 0, 0);
        check_eq("unhold_a", {16'h0, d0a}, 32'h0000_7777);

        cyc("z0", 1, 4'd0, 32'hFFFF_FFFF, 1, 4'd0, 1, 4'd0, 1, 4'd0);
        check_eq("z0d", d1a, 32'h0);
        check_eq("z0b", {31'h0, b1b}, 32'h0);
        cyc("z0rd", 0, 0, 0, 0, 0, 1, 4'd0, 0, 0);
        check_eq("z0rdd", d1a, 32'h0);
        cyc("wr15", 1, 4'd15, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0);
        cyc("rd15", 0, 0, 0, 0, 0, 1, 4'd15, 1, 4'd15);
        check_eq("r15", d1b, 32'hCAFE_F00D);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rrst");
            cyc("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
